// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage with PC select, IF/ID register and interrupt acceptance
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter logic [31:0] INTR_VECTOR  = 32'h80000004,
  parameter logic [31:0] EXCP_VECTOR  = 32'h80000008,
  parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JrTarget,
  input  logic        IRQ,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] EPC,
  output logic        IntrTaken
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pcp4_q, pcp4_d, epc_q, epc_d;
  logic        valid_q, valid_d, taken_q, taken_d;
  logic [31:0] pc_plus4, redirect_target;
  logic        redirect, accept, squash;
  always_comb begin
    pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    redirect = (PCSrc >= 3'd1) && (PCSrc <= 3'd4);
    accept = IRQ & ~pc_q[31] & ~Stall & ~reset & ~redirect;
    squash = Flush | accept;
    redirect_target = (PCSrc == 3'd1) ? BranchTarget :
                      (PCSrc == 3'd2) ? {pc_plus4[31:28], JumpIndex, 2'b00} :
                      (PCSrc == 3'd3) ? JrTarget : EXCP_VECTOR;
    pc_d = Stall ? pc_q : redirect ? redirect_target : accept ? INTR_VECTOR : pc_plus4;
    // a flush during stall squashes the held word but keeps its PC+4
    instr_d = (Stall ? Flush : squash) ? NOP_WORD : (Stall ? instr_q : Instruction);
    valid_d = Stall ? valid_q & ~Flush : ~squash;
    pcp4_d = Stall ? pcp4_q : pc_plus4;
    epc_d = accept ? pc_q : epc_q;
    taken_d = accept;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
      instr_q <= NOP_WORD;
      pcp4_q <= 32'd0;
      valid_q <= 1'b0;
      epc_q <= 32'd0;
      taken_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      pcp4_q <= pcp4_d;
      valid_q <= valid_d;
      epc_q <= epc_d;
      taken_q <= taken_d;
    end
  end
  assign Address = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4 = pcp4_q;
  assign IF_ID_Valid = valid_q;
  assign EPC = epc_q;
  assign IntrTaken = taken_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table plus scoreboard check of the fetch stage
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1, Stall = 1'b0, Flush = 1'b0, IRQ = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic [31:0] BranchTarget = '0, JrTarget = '0, Instruction = '0;
  logic [25:0] JumpIndex = '0;
  logic [31:0] Address, IF_ID_Instruction, IF_ID_PCPlus4, EPC;
  logic        IF_ID_Valid, IntrTaken;
  int n_chk = 0, n_fail = 0;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .JumpIndex(JumpIndex), .JrTarget(JrTarget),
    .IRQ(IRQ), .Instruction(Instruction), .Address(Address),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .EPC(EPC), .IntrTaken(IntrTaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, stl, fl;
    logic [2:0] src;
    logic [31:0] tgt;
    logic irq;
    logic [31:0] ins;
    logic [31:0] addr, iins, ip4;
    logic ck4, val;
    logic [31:0] epc;
    logic tk;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic rst, logic stl, logic fl, logic [2:0] src, logic [31:0] tgt,
                              logic irq, logic [31:0] ins, logic [31:0] addr, logic [31:0] iins,
                              logic [31:0] ip4, logic ck4, logic val, logic [31:0] epc, logic tk);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fl = fl; v.src = src; v.tgt = tgt; v.irq = irq; v.ins = ins;
    v.addr = addr; v.iins = iins; v.ip4 = ip4; v.ck4 = ck4; v.val = val; v.epc = epc; v.tk = tk;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst; Stall = v.stl; Flush = v.fl; PCSrc = v.src; IRQ = v.irq;
    BranchTarget = v.tgt; JrTarget = v.tgt; JumpIndex = v.tgt[25:0]; Instruction = v.ins;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk("Address", idx, Address, e.addr);
      chk("IF_ID_Instruction", idx, IF_ID_Instruction, e.iins);
      if (e.ck4) chk("IF_ID_PCPlus4", idx, IF_ID_PCPlus4, e.ip4);
      chk("IF_ID_Valid", idx, {31'd0, IF_ID_Valid}, {31'd0, e.val});
      chk("EPC", idx, EPC, e.epc);
      chk("IntrTaken", idx, {31'd0, IntrTaken}, {31'd0, e.tk});
    end
  endtask

  initial begin
    logic [31:0] pc, r;
    //           rst stl fl src  tgt           irq ins            addr          iins          ip4          ck4 val epc           tk
    tbl.push_back(mk(1, 0, 0, 3'd0, 32'h0,        0, 32'h08000003, 32'h80000000, 32'h0,        32'h0,        1, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 3'd0, 32'h0,        0, 32'h08000003, 32'h80000000, 32'h0,        32'h0,        1, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        0, 32'h08000003, 32'h80000004, 32'h08000003, 32'h80000004, 1, 1, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 3'd2, 32'h3,        0, 32'h11111111, 32'h8000000C, 32'h11111111, 32'h80000008, 1, 1, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'hB4,       0, 32'h22222222, 32'h000000B4, 32'h22222222, 32'h80000010, 1, 1, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        0, 32'h33333333, 32'h000000B8, 32'h33333333, 32'h000000B8, 1, 1, 32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        1, 32'h44444444, 32'h80000004, 32'h0,        32'h0,        0, 0, 32'h000000B8, 1));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        1, 32'h55555555, 32'h80000008, 32'h55555555, 32'h80000008, 1, 1, 32'h000000B8, 0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'hB8,       1, 32'h66666666, 32'h000000B8, 32'h66666666, 32'h8000000C, 1, 1, 32'h000000B8, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        1, 32'h77777777, 32'h80000004, 32'h0,        32'h0,        0, 0, 32'h000000B8, 1));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'h200,      0, 32'h88888888, 32'h00000200, 32'h88888888, 32'h80000008, 1, 1, 32'h000000B8, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        0, 32'h99999999, 32'h00000204, 32'h99999999, 32'h00000204, 1, 1, 32'h000000B8, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,      1, 32'hAAAAAAAA, 32'h00000204, 32'h99999999, 32'h00000204, 1, 1, 32'h000000B8, 0));
    tbl.push_back(mk(0, 1, 1, 3'd0, 32'h0,        1, 32'hAAAAAAAA, 32'h00000204, 32'h0,        32'h00000204, 1, 0, 32'h000000B8, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        1, 32'hBBBBBBBB, 32'h80000004, 32'h0,        32'h0,        0, 0, 32'h00000204, 1));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'h40,       0, 32'hCCCCCCCC, 32'h00000040, 32'hCCCCCCCC, 32'h80000008, 1, 1, 32'h00000204, 0));
    tbl.push_back(mk(0, 0, 0, 3'd1, 32'h100,      1, 32'hDDDDDDDD, 32'h00000100, 32'hDDDDDDDD, 32'h00000044, 1, 1, 32'h00000204, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        1, 32'hEEEEEEEE, 32'h80000004, 32'h0,        32'h0,        0, 0, 32'h00000100, 1));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        0, 32'h0,        32'h80000008, 32'h0,        32'h80000008, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'hFFFFFFFC, 0, 32'h12345678, 32'hFFFFFFFC, 32'h12345678, 32'h8000000C, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd0, 32'h0,        0, 32'h23456789, 32'h80000000, 32'h23456789, 32'h80000000, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'h40,       0, 32'h1,        32'h00000040, 32'h1,        32'h80000004, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd4, 32'h0,        0, 32'h2,        32'h80000008, 32'h2,        32'h00000044, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'h40,       0, 32'h3,        32'h00000040, 32'h3,        32'h8000000C, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd4, 32'h0,        1, 32'h4,        32'h80000008, 32'h4,        32'h00000044, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd3, 32'h40,       0, 32'h5,        32'h00000040, 32'h5,        32'h8000000C, 1, 1, 32'h00000100, 0));
    tbl.push_back(mk(0, 0, 0, 3'd5, 32'h0,        1, 32'h6,        32'h80000004, 32'h0,        32'h0,        0, 0, 32'h00000040, 1));
    tbl.push_back(mk(0, 0, 0, 3'd7, 32'h0,        0, 32'h7,        32'h80000008, 32'h7,        32'h80000008, 1, 1, 32'h00000040, 0));
    tbl.push_back(mk(0, 0, 1, 3'd1, 32'h300,      0, 32'h8,        32'h00000300, 32'h0,        32'h0,        0, 0, 32'h00000040, 0));
    tbl.push_back(mk(0, 1, 0, 3'd0, 32'h0,        0, 32'h9,        32'h00000300, 32'h0,        32'h0,        0, 0, 32'h00000040, 0));
    tbl.push_back(mk(1, 1, 0, 3'd0, 32'h0,        1, 32'h9,        32'h80000000, 32'h0,        32'h0,        1, 0, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 3'd3, 32'h40,       1, 32'h9,        32'h80000000, 32'h0,        32'h0,        1, 0, 32'h0,        0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    // sequential run in user space with random words, then an interrupt
    r = $urandom;
    step(mk(0, 0, 0, 3'd3, 32'h1000, 0, r, 32'h00001000, r, 32'h80000004, 1, 1, 32'h0, 0), 100);
    pc = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      step(mk(0, 0, 0, 3'($urandom_range(5, 7)) & 3'd0, 32'h0, 0, r, pc + 32'd4, r, pc + 32'd4, 1, 1, 32'h0, 0), 101 + i);
      pc = pc + 32'd4;
    end
    step(mk(0, 0, 0, 3'd6, 32'h0, 1, 32'hCAFE0000, 32'h80000004, 32'h0, 32'h0, 0, 0, pc, 1), 110);
    step(mk(0, 0, 0, 3'd0, 32'h0, 1, 32'hCAFE0001, 32'h80000008, 32'hCAFE0001, 32'h80000008, 1, 1, pc, 0), 111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
